// File: rtl/pt2262_frame_tx.sv
// PT2262-style frame encoder: N_SYM tri-state code bits plus a sync bit per frame,
// repeated n_frames times, with slot-rate divider, abort and start/busy/done handshake.
module pt2262_frame_tx #(
    parameter int N_SYM = 12,
    parameter int DIV   = 16,
    parameter int REP_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [2*N_SYM-1:0]   i_sym,
    input  logic [REP_W-1:0]     i_n_frames,
    output logic                 o_q,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_frame_end
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (N_SYM > 1) ? $clog2(N_SYM) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SYM - 1);

    typedef enum logic [1:0] {IDLE, DATA, SYNC} state_t;

    state_t                    r_state;
    logic [DIV_W-1:0]          r_div;
    logic [6:0]                r_slot;
    logic [IDX_W-1:0]          r_idx;
    logic [REP_W-1:0]          r_frames;
    logic [N_SYM-1:0][1:0]     r_sym;
    logic                      r_q;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_frame_end;

    state_t                    w_nstate;
    logic [6:0]                w_nslot;
    logic [IDX_W-1:0]          w_nidx;
    logic                      w_nq;
    logic                      w_slot_adv;
    logic                      w_sync_end;

    // Float is the zero pattern for slots 0..15 and the one pattern for 16..31.
    function automatic logic codeBit(input logic [1:0] s, input logic [4:0] slot);
        logic zeroBit;
        logic oneBit;
        zeroBit = (slot[3:2] == 2'b00);
        oneBit  = (slot[3:2] != 2'b11);
        case (s)
            2'b00:   codeBit = zeroBit;
            2'b01:   codeBit = oneBit;
            default: codeBit = slot[4] ? oneBit : zeroBit;
        endcase
    endfunction

    // Position the encoder moves to on the next slot boundary, and the q it will show there.
    always_comb begin
        w_nstate   = r_state;
        w_nslot    = r_slot;
        w_nidx     = r_idx;
        w_slot_adv = (r_div == DIV_LAST);
        w_sync_end = (r_state == SYNC) && (r_slot == 7'd127);
        case (r_state)
            DATA: begin
                if (r_slot == 7'd31) begin
                    w_nslot = 7'd0;
                    if (r_idx == IDX_LAST) begin
                        w_nstate = SYNC;
                        w_nidx   = '0;
                    end else begin
                        w_nidx = r_idx + 1'b1;
                    end
                end else begin
                    w_nslot = r_slot + 1'b1;
                end
            end
            SYNC: begin
                if (w_sync_end) begin
                    w_nslot  = 7'd0;
                    w_nidx   = '0;
                    w_nstate = (r_frames != '0) ? DATA : IDLE;
                end else begin
                    w_nslot = r_slot + 1'b1;
                end
            end
            default: ;
        endcase
        case (w_nstate)
            DATA:    w_nq = codeBit(r_sym[w_nidx], w_nslot[4:0]);
            SYNC:    w_nq = (w_nslot < 7'd4);
            default: w_nq = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_slot      <= '0;
            r_idx       <= '0;
            r_frames    <= '0;
            r_sym       <= '0;
            r_q         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_end <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_frame_end <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state  <= DATA;
                        r_div    <= '0;
                        r_slot   <= '0;
                        r_idx    <= '0;
                        r_sym    <= i_sym;
                        r_frames <= (i_n_frames == '0) ? '0 : i_n_frames - 1'b1;
                        r_q      <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                default: begin
                    if (i_abort) begin
                        r_state  <= IDLE;
                        r_div    <= '0;
                        r_slot   <= '0;
                        r_idx    <= '0;
                        r_frames <= '0;
                        r_q      <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (w_slot_adv) begin
                        r_div   <= '0;
                        r_state <= w_nstate;
                        r_slot  <= w_nslot;
                        r_idx   <= w_nidx;
                        r_q     <= w_nq;
                        if (w_sync_end) begin
                            r_frame_end <= 1'b1;
                            if (r_frames != '0) begin
                                r_frames <= r_frames - 1'b1;
                            end else begin
                                r_busy <= 1'b0;
                                r_done <= 1'b1;
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_q         = r_q;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_frame_end = r_frame_end;

endmodule

// File: tb/tb_pt2262_frame_tx.sv
// Self-checking bench for pt2262_frame_tx: compares {q,busy,done,frame_end} every clk
// against a run-length waveform model built from the PT2262 code-bit rules.
module tb_pt2262_frame_tx;

   localparam int N = 12;
   localparam int D = 3;
   localparam int L = (32 * N + 128) * D;

   logic           clk;
   logic           rst;
   logic           start;
   logic           abort;
   logic [2*N-1:0] sym;
   logic [3:0]     nFrames;
   logic           q;
   logic           busy;
   logic           done;
   logic           frameEnd;

   int checks;
   int fails;
   bit frameQ[$];

   pt2262_frame_tx #(.N_SYM(N), .DIV(D), .REP_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start),
      .i_abort     (abort),
      .i_sym       (sym),
      .i_n_frames  (nFrames),
      .o_q         (q),
      .o_busy      (busy),
      .o_done      (done),
      .o_frame_end (frameEnd)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single point where every comparison is counted and reported.
   task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got {q,busy,done,fe}=%b, expected %b", tag, obs, exp);
      end
   endtask

   // One frame of q, one entry per clk, from the high/low run lengths of each code bit.
   task automatic buildFrame(input logic [2*N-1:0] s);
      int runs[4];
      frameQ.delete();
      for (int k = 0; k < N; k++) begin
         case (s[2*k +: 2])
            2'b00:   runs = '{4, 12, 4, 12};
            2'b01:   runs = '{12, 4, 12, 4};
            default: runs = '{4, 12, 12, 4};
         endcase
         for (int r = 0; r < 4; r++)
            for (int i = 0; i < runs[r] * D; i++)
               frameQ.push_back(r % 2 == 0);
      end
      for (int i = 0; i < 4 * D; i++)   frameQ.push_back(1'b1);
      for (int i = 0; i < 124 * D; i++) frameQ.push_back(1'b0);
   endtask

   // Idle clocks: everything low; optionally assert abort, which idle must ignore.
   task automatic idleCycles(input int n, input bit withAbort);
      for (int i = 0; i < n; i++) begin
         abort = withAbort;
         @(negedge clk);
         checkOutput($sformatf("idle%0d", i), {q, busy, done, frameEnd}, 4'b0000);
      end
      abort = 1'b0;
   endtask

   // Starts one transmission at the current negedge and checks every clk until done
   // (or until the clk after an abort/reset at cycle killAt). Returns at a negedge.
   task automatic applyStimulus(input int nf, input logic [2*N-1:0] s, input int killAt,
                                input bit killRst, input bit noise, input bit withAbort);
      int f;
      logic [3:0] exp;
      f = (nf == 0) ? 1 : nf;
      buildFrame(s);
      start   = 1'b1;
      abort   = withAbort;
      sym     = s;
      nFrames = 4'(nf);
      for (int c = 1; c <= f * L + 1; c++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         rst   = 1'b0;
         if (killAt != 0 && c == killAt + 1)
            exp = 4'b0000;
         else if (c == f * L + 1)
            exp = 4'b0011;
         else
            exp = {frameQ[(c - 1) % L], 1'b1, 1'b0, (c > 1) && ((c - 1) % L == 0)};
         checkOutput($sformatf("nf%0d_c%0d", nf, c), {q, busy, done, frameEnd}, exp);
         if (killAt != 0 && c == killAt + 1) break;
         if (c == killAt) begin
            if (killRst) rst = 1'b1;
            else         abort = 1'b1;
         end else if (noise && $urandom_range(0, 99) == 0) begin
            start   = 1'b1;
            sym     = (2*N)'($urandom);
            nFrames = 4'($urandom);
         end
      end
      start = 1'b0;
   endtask

   initial begin
      logic [2*N-1:0] s;
      int nf;
      int killAt;
      checks  = 0;
      fails   = 0;
      rst     = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      sym     = '0;
      nFrames = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset", {q, busy, done, frameEnd}, 4'b0000);
      rst = 1'b0;
      idleCycles(3, 1'b1);

      applyStimulus(1, '0, 0, 1'b0, 1'b0, 1'b0);
      idleCycles(2, 1'b0);

      s = (2*N)'($urandom);
      s[3:0] = 4'b1001;
      applyStimulus(1, s, 0, 1'b0, 1'b0, 1'b0);

      // Back-to-back starts in the done clk: n_frames 0 then 3.
      applyStimulus(0, (2*N)'($urandom), 0, 1'b0, 1'b0, 1'b0);
      applyStimulus(3, (2*N)'($urandom), 0, 1'b0, 1'b0, 1'b0);

      applyStimulus(2, (2*N)'($urandom), 0, 1'b0, 1'b1, 1'b1);

      applyStimulus(3, (2*N)'($urandom), L + 100, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, (2*N)'($urandom), 32 * N * D + 50, 1'b1, 1'b0, 1'b0);
      idleCycles(2, 1'b0);

      for (int t = 0; t < 6; t++) begin
         nf     = $urandom_range(0, 2);
         killAt = 0;
         if ($urandom_range(0, 2) == 0)
            killAt = $urandom_range(1, ((nf == 0) ? 1 : nf) * L);
         applyStimulus(nf, (2*N)'($urandom), killAt, 1'($urandom), 1'b1, 1'b0);
         idleCycles($urandom_range(0, 3), 1'($urandom));
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
